touch_panel_spi_responder: RTL and testbench

SPI slave that emulates an XPT2046/ADS7843-style resistive touch-panel controller, clocked by the fabric clock. It is the far end of the touch-panel SPI master link: mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. It decodes command bytes, latches the selected 12-bit measurement, and shifts it back over the following 16 SCLK cycles. It serves as a bench and board-level stand-in for the real controller and as a loopback target for the master's driver.

---
 rtl/touch_panel_spi_responder.sv | 183 ++++++++++++++++++
 tb/tb_touch_panel_spi_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_panel_spi_responder.sv
// rtl/touch_panel_spi_responder.sv - XPT2046/ADS7843-style touch-panel SPI slave emulator
module touch_panel_spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  input  logic [11:0] x_value,
  input  logic [11:0] y_value,
  input  logic [11:0] z1_value,
  input  logic [11:0] z2_value,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic [7:0]  rx_byte,
  output logic        rx_valid,
  output logic        frame_err
);

  typedef enum logic [1:0] {IDLE, CMD_ACCEPT, RESP} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic                   sclk_prev_q, sclk_prev_d;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [15:0] tx_reg_q, tx_reg_d;
  logic [4:0]  tx_cnt_q, tx_cnt_d;
  logic        miso_bit_q, miso_bit_d;
  logic        miso_q, miso_d;
  logic        armed_q, armed_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  cmd_byte_q, cmd_byte_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic        rx_valid_q, rx_valid_d;
  logic        frame_err_q, frame_err_d;

  logic        sclk_s, mosi_s, ss_n_s;
  logic        sclk_rise, sclk_fall;
  logic [7:0]  byte_done;
  logic [11:0] sel_data;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_s    = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign byte_done = {shift_q, mosi_s};

  assign MISO      = miso_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_byte  = cmd_byte_q;
  assign rx_byte   = rx_byte_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

  // Next values of the pin synchronizers and the delayed SCLK used for edge detection
  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_n};
    sclk_prev_d = sclk_s;
  end

  // Measurement selected by the command byte sitting in rx_byte during CMD_ACCEPT
  always_comb begin
    case (rx_byte_q[6:4])
      3'b101:  sel_data = x_value;
      3'b001:  sel_data = y_value;
      3'b011:  sel_data = z1_value;
      3'b100:  sel_data = z2_value;
      default: sel_data = 12'h000;
    endcase
  end

  // Byte assembly, command decode and response shifting
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    tx_reg_d    = tx_reg_q;
    tx_cnt_d    = tx_cnt_q;
    miso_bit_d  = miso_bit_q;
    cmd_valid_d = 1'b0;
    cmd_byte_d  = cmd_byte_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    // After reset a frame only counts once SS_n has been seen high
    armed_d     = armed_q | ss_n_s;

    if (ss_n_s) begin
      // Deselect at a byte boundary keeps the response alive; mid-byte aborts it
      bit_cnt_d = 3'd0;
      if (bit_cnt_q != 3'd0) begin
        frame_err_d = 1'b1;
        state_d     = IDLE;
        tx_reg_d    = 16'h0000;
        tx_cnt_d    = 5'd0;
      end
    end else if (armed_q) begin
      if (sclk_rise) begin
        shift_d = byte_done[6:0];
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d  = 3'd0;
          rx_byte_d  = byte_done;
          rx_valid_d = 1'b1;
          if (state_q == IDLE && byte_done[7]) state_d = CMD_ACCEPT;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        // The 16th rise of the response ends it; a command finishing on it is executed
        if (state_q == RESP && tx_cnt_q == 5'd0)
          state_d = (bit_cnt_q == 3'd7 && byte_done[7]) ? CMD_ACCEPT : IDLE;
      end
      if (sclk_fall && state_q == RESP && tx_cnt_q != 5'd0) begin
        miso_bit_d = tx_reg_q[15];
        tx_reg_d   = {tx_reg_q[14:0], 1'b0};
        tx_cnt_d   = tx_cnt_q - 5'd1;
      end
    end

    if (state_q == CMD_ACCEPT) begin
      cmd_valid_d = 1'b1;
      cmd_byte_d  = rx_byte_q;
      frame_err_d = 1'b0;
      miso_bit_d  = 1'b0;
      tx_reg_d    = rx_byte_q[3] ? {1'b0, sel_data[11:4], 7'b0} : {1'b0, sel_data, 3'b000};
      tx_cnt_d    = 5'd16;
      state_d     = RESP;
    end

    // The last shifted bit is held across a byte-boundary deselect and re-driven on reselect
    miso_d = (!ss_n_s && armed_q && state_q == RESP) ? miso_bit_d : 1'b0;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '0;
      sclk_prev_q <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 7'd0;
      tx_reg_q    <= 16'h0000;
      tx_cnt_q    <= 5'd0;
      miso_bit_q  <= 1'b0;
      miso_q      <= 1'b0;
      armed_q     <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_byte_q  <= 8'h00;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_sync_q   <= ss_sync_d;
      sclk_prev_q <= sclk_prev_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      tx_reg_q    <= tx_reg_d;
      tx_cnt_q    <= tx_cnt_d;
      miso_bit_q  <= miso_bit_d;
      miso_q      <= miso_d;
      armed_q     <= armed_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_byte_q  <= cmd_byte_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_touch_panel_spi_responder.sv
// tb/tb_touch_panel_spi_responder.sv - SPI master bench with a response model
module tb_touch_panel_spi_responder;

  localparam int HALF  = 8;
  localparam int SETUP = 6;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        SCLK, MOSI, SS_n;
  logic        MISO;
  logic [11:0] x_value, y_value, z1_value, z2_value;
  logic        cmd_valid;
  logic [7:0]  cmd_byte;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        frame_err;

  int total = 0;
  int bad   = 0;
  int rx_cnt = 0;
  int cmd_cnt = 0;
  int cmd_timing_bad = 0;
  logic rx_valid_prev = 1'b0;

  touch_panel_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n), .MISO(MISO),
    .x_value(x_value), .y_value(y_value), .z1_value(z1_value), .z2_value(z2_value),
    .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Pulse counters; a cmd_valid must follow the rx_valid of the same byte by one clk
  always @(negedge clk) begin
    if (rx_valid) rx_cnt++;
    if (cmd_valid) begin
      cmd_cnt++;
      if (!rx_valid_prev || rx_byte !== cmd_byte) cmd_timing_bad++;
    end
    rx_valid_prev = rx_valid;
  end

  // Response word from the command rules: busy bit, data, zero pad
  function automatic logic [15:0] model_word(input logic [7:0] cmd);
    logic [15:0] d;
    d = 16'h0000;
    if (cmd[6:4] == 3'd5) d = {4'h0, x_value};
    if (cmd[6:4] == 3'd1) d = {4'h0, y_value};
    if (cmd[6:4] == 3'd3) d = {4'h0, z1_value};
    if (cmd[6:4] == 3'd4) d = {4'h0, z2_value};
    if (cmd[3]) return (d >> 4) << 7;
    return d << 3;
  endfunction

  task automatic xfer_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      MOSI = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i] = MISO;
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
  endtask

  task automatic select(input logic level);
    SS_n = level;
    repeat (SETUP) @(negedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input bit toggle, output logic [23:0] got);
    logic [7:0] r0, r1, r2;
    select(1'b0);
    xfer_byte(b0, r0);
    if (toggle) begin select(1'b1); select(1'b0); end
    xfer_byte(b1, r1);
    if (toggle) begin select(1'b1); select(1'b0); end
    xfer_byte(b2, r2);
    select(1'b1);
    got = {r0, r1, r2};
  endtask

  task automatic test_reset();
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL reset_miso got=%b want=0", MISO); end
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL reset_cmd_valid got=%b want=0", cmd_valid); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    total++; if (cmd_byte !== 8'h00) begin bad++; $display("FAIL reset_cmd_byte got=%h want=00", cmd_byte); end
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte got=%h want=00", rx_byte); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
  endtask

  task automatic test_x_read_12bit();
    logic [23:0] got, exp;
    int c0;
    x_value = 12'hABC; y_value = 12'($urandom); z1_value = 12'($urandom); z2_value = 12'($urandom);
    exp = {8'h00, model_word(8'hD0)};
    c0 = cmd_cnt;
    run_frame(8'hD0, 8'h00, 8'h00, 1'b0, got);
    total++; if (cmd_cnt - c0 !== 1) begin bad++; $display("FAIL x12_cmd_count got=%0d want=1", cmd_cnt - c0); end
    total++; if (cmd_byte !== 8'hD0) begin bad++; $display("FAIL x12_cmd_byte got=%h want=d0", cmd_byte); end
    total++; if (got !== exp) begin bad++; $display("FAIL x12_miso got=%h want=%h", got, exp); end
  endtask

  task automatic test_y_read_8bit_toggle();
    logic [23:0] got, exp;
    y_value = 12'h3F7; x_value = 12'($urandom);
    exp = {8'h00, model_word(8'h98)};
    run_frame(8'h98, 8'h00, 8'h00, 1'b1, got);
    total++; if (got !== exp) begin bad++; $display("FAIL y8_miso got=%h want=%h", got, exp); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL y8_frame_err got=%b want=0", frame_err); end
  endtask

  task automatic test_random_reads();
    logic [23:0] got, exp;
    logic [7:0] cmd;
    bit tog;
    int c0;
    for (int n = 0; n < 10; n++) begin
      x_value = 12'($urandom); y_value = 12'($urandom);
      z1_value = 12'($urandom); z2_value = 12'($urandom);
      cmd = 8'h80 | 8'($urandom_range(0, 127));
      tog = 1'($urandom_range(0, 1));
      exp = {8'h00, model_word(cmd)};
      c0 = cmd_cnt;
      run_frame(cmd, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 127)), tog, got);
      total++; if (got !== exp) begin bad++; $display("FAIL rand_miso cmd=%h got=%h want=%h", cmd, got, exp); end
      total++; if (cmd_cnt - c0 !== 1 || cmd_byte !== cmd) begin
        bad++; $display("FAIL rand_cmd cnt=%0d byte=%h want cnt=1 byte=%h", cmd_cnt - c0, cmd_byte, cmd);
      end
    end
  endtask

  task automatic test_abort();
    logic [23:0] got, exp;
    logic [7:0] cmd;
    int c0;
    cmd = 8'hD0;
    c0 = cmd_cnt;
    select(1'b0);
    for (int i = 7; i >= 4; i--) begin
      MOSI = cmd[i];
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    select(1'b1);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL abort_frame_err got=%b want=1", frame_err); end
    total++; if (cmd_cnt !== c0) begin bad++; $display("FAIL abort_cmd_count got=%0d want=%0d", cmd_cnt, c0); end
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL abort_miso got=%b want=0", MISO); end
    z1_value = 12'h123;
    exp = {8'h00, model_word(8'hB0)};
    run_frame(8'hB0, 8'h00, 8'h00, 1'b0, got);
    total++; if (got !== exp) begin bad++; $display("FAIL abort_z1_miso got=%h want=%h", got, exp); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL abort_clear got=%b want=0", frame_err); end
  endtask

  task automatic test_non_cmd();
    logic [7:0] r0, r1;
    int c0, x0;
    c0 = cmd_cnt;
    x0 = rx_cnt;
    select(1'b0);
    xfer_byte(8'h50, r0);
    total++; if (rx_cnt - x0 !== 1) begin bad++; $display("FAIL noncmd_rx_count got=%0d want=1", rx_cnt - x0); end
    total++; if (rx_byte !== 8'h50) begin bad++; $display("FAIL noncmd_rx_byte got=%h want=50", rx_byte); end
    xfer_byte(8'h00, r1);
    select(1'b1);
    total++; if (cmd_cnt !== c0) begin bad++; $display("FAIL noncmd_cmd_count got=%0d want=%0d", cmd_cnt, c0); end
    total++; if ({r0, r1} !== 16'h0000) begin bad++; $display("FAIL noncmd_miso got=%h want=0000", {r0, r1}); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r [5];
    logic [15:0] wx, wy;
    logic [39:0] got, exp;
    int c0;
    x_value = 12'($urandom); y_value = 12'($urandom);
    wx = model_word(8'hD0);
    wy = model_word(8'h90);
    exp = {8'h00, wx, wy};
    c0 = cmd_cnt;
    select(1'b0);
    xfer_byte(8'hD0, r[0]);
    x_value = ~x_value;
    xfer_byte(8'h00, r[1]);
    xfer_byte(8'h90, r[2]);
    xfer_byte(8'h00, r[3]);
    xfer_byte(8'h00, r[4]);
    select(1'b1);
    got = {r[0], r[1], r[2], r[3], r[4]};
    total++; if (cmd_cnt - c0 !== 2) begin bad++; $display("FAIL overlap_cmd_count got=%0d want=2", cmd_cnt - c0); end
    total++; if (cmd_byte !== 8'h90) begin bad++; $display("FAIL overlap_cmd_byte got=%h want=90", cmd_byte); end
    total++; if (got !== exp) begin bad++; $display("FAIL overlap_miso got=%h want=%h", got, exp); end
  endtask

  task automatic test_reset_in_resp();
    logic [7:0] r0;
    logic [23:0] got, exp;
    int x0, c0;
    x_value = 12'hFFF;
    select(1'b0);
    xfer_byte(8'hD0, r0);
    for (int i = 0; i < 4; i++) begin
      MOSI = 1'b0;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rst_pre_miso got=%b want=1", MISO); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b want=0", MISO); end
    total++; if ({cmd_valid, rx_valid, frame_err, cmd_byte, rx_byte} !== 19'd0) begin
      bad++; $display("FAIL rst_outputs got=%b/%b/%b/%h/%h want=0/0/0/00/00", cmd_valid, rx_valid, frame_err, cmd_byte, rx_byte);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    x0 = rx_cnt;
    xfer_byte(8'hD0, r0);
    total++; if (rx_cnt !== x0) begin bad++; $display("FAIL rst_unarmed_rx got=%0d want=%0d", rx_cnt, x0); end
    select(1'b1);
    exp = {8'h00, model_word(8'hD0)};
    c0 = cmd_cnt;
    run_frame(8'hD0, 8'h00, 8'h00, 1'b0, got);
    total++; if (got !== exp) begin bad++; $display("FAIL rst_after_miso got=%h want=%h", got, exp); end
    total++; if (cmd_cnt - c0 !== 1) begin bad++; $display("FAIL rst_after_cmd got=%0d want=1", cmd_cnt - c0); end
  endtask

  task automatic test_cmd_timing();
    total++; if (cmd_timing_bad !== 0) begin bad++; $display("FAIL cmd_after_rx violations=%0d want=0", cmd_timing_bad); end
  endtask

  initial begin
    reset_n = 1'b0;
    SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
    x_value = 12'h000; y_value = 12'h000; z1_value = 12'h000; z2_value = 12'h000;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    test_x_read_12bit();
    test_y_read_8bit_toggle();
    test_random_reads();
    test_abort();
    test_non_cmd();
    test_back_to_back();
    test_reset_in_resp();
    test_cmd_timing();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
